// File: rtl/ula_seq_if.sv
// ula_seq_if
//   Bundles the signals between the operand sequencer and its surroundings:
//   the switch/button panel, the downstream ALU and the result display.
//
//   Signals (names follow the existing ALU board wiring):
//     Dado_in      switch bus: carries A, then B, then {C, op} in bits [3:0]
//     Confirma_in  confirm button level
//     Cancela_in   abort level
//     Acumula_in   accumulate select, sampled on a confirm in EXIBE
//     Resultado_in ALU Saida_out
//     Flags_in     ALU Flags_out
//     A_out, B_out, C_out, Operacao_out  operands and control to the ALU
//     Resultado_out, Flags_out           latched result and flags
//     Estado_out   current state code (debug/observability)
//     Valido_out   high only while the latched result is on display
//
//   Modports:
//     slave  - the sequencer (consumes panel/ALU inputs, drives the outputs)
//     master - the panel/ALU side (drives the inputs, observes the outputs)
interface ula_seq_if #(
    parameter int LARGURA = 8
);
    logic [LARGURA-1:0] Dado_in;
    logic               Confirma_in;
    logic               Cancela_in;
    logic               Acumula_in;
    logic [LARGURA-1:0] Resultado_in;
    logic [2:0]         Flags_in;
    logic [LARGURA-1:0] A_out;
    logic [LARGURA-1:0] B_out;
    logic               C_out;
    logic [2:0]         Operacao_out;
    logic [LARGURA-1:0] Resultado_out;
    logic [2:0]         Flags_out;
    logic [2:0]         Estado_out;
    logic               Valido_out;

    modport slave (
        input  Dado_in, Confirma_in, Cancela_in, Acumula_in, Resultado_in, Flags_in,
        output A_out, B_out, C_out, Operacao_out, Resultado_out, Flags_out,
        output Estado_out, Valido_out
    );

    modport master (
        output Dado_in, Confirma_in, Cancela_in, Acumula_in, Resultado_in, Flags_in,
        input  A_out, B_out, C_out, Operacao_out, Resultado_out, Flags_out,
        input  Estado_out, Valido_out
    );
endinterface

// File: rtl/ula_sequenciador.sv
// ula_sequenciador
//   Operand/control sequencer that sits directly upstream of ULA_8Bits.
//   A, B and {carry, operation} are entered one at a time on a shared switch
//   bus, each confirmed by a push-button. The ALU is then given a fixed
//   settle time (ESPERA_CICLOS cycles in EXECUTA) before its result and flags
//   are latched for display. Accumulate mode feeds the latched result back
//   as the next A operand.
//
//   Ports:
//     Clock_in  single system clock, rising edge
//     Reset_in  synchronous, active-high reset
//     bus       ula_seq_if.slave (panel inputs, ALU inputs/outputs, display)
//
//   Button handshake: Confirma_in is a level. A confirm "pulse" is its rising
//   edge (Confirma_in & ~prev), so one press produces exactly one pulse no
//   matter how long it is held. Cancela_in is a level that takes priority over
//   a pulse in the same cycle; Reset_in takes priority over everything.
module ula_sequenciador #(
    parameter int LARGURA       = 8,
    parameter int ESPERA_CICLOS = 2
) (
    input  logic    Clock_in,
    input  logic    Reset_in,
    ula_seq_if.slave bus
);

    localparam logic [2:0] CARREGA_A  = 3'd0;
    localparam logic [2:0] CARREGA_B  = 3'd1;
    localparam logic [2:0] CARREGA_OP = 3'd2;
    localparam logic [2:0] EXECUTA    = 3'd3;
    localparam logic [2:0] EXIBE      = 3'd4;

    // Last counter value in EXECUTA; the capture happens on that edge so the
    // state lasts exactly ESPERA_CICLOS cycles.
    localparam logic [3:0] ULTIMO = 4'(ESPERA_CICLOS - 1);

    logic [2:0]         estado;
    logic [3:0]         contador;
    logic               confirma_ant;
    logic               pulso;
    logic [LARGURA-1:0] a_reg;
    logic [LARGURA-1:0] b_reg;
    logic               c_reg;
    logic [2:0]         op_reg;
    logic [LARGURA-1:0] res_reg;
    logic [2:0]         flags_reg;

    assign pulso = bus.Confirma_in & ~confirma_ant;

    always_ff @(posedge Clock_in) begin
        if (Reset_in) begin
            estado       <= CARREGA_A;
            contador     <= '0;
            // Held at 1 so a button still pressed through reset is not
            // seen as a fresh press when reset is released.
            confirma_ant <= 1'b1;
            a_reg        <= '0;
            b_reg        <= '0;
            c_reg        <= 1'b0;
            op_reg       <= '0;
            res_reg      <= '0;
            flags_reg    <= '0;
        end else begin
            confirma_ant <= bus.Confirma_in;
            if (bus.Cancela_in) begin
                // Abort keeps every latched value; only the state moves.
                estado <= CARREGA_A;
            end else begin
                case (estado)
                    CARREGA_A: begin
                        if (pulso) begin
                            a_reg  <= bus.Dado_in;
                            estado <= CARREGA_B;
                        end
                    end
                    CARREGA_B: begin
                        if (pulso) begin
                            b_reg  <= bus.Dado_in;
                            estado <= CARREGA_OP;
                        end
                    end
                    CARREGA_OP: begin
                        if (pulso) begin
                            op_reg   <= bus.Dado_in[2:0];
                            c_reg    <= bus.Dado_in[3];
                            contador <= '0;
                            estado   <= EXECUTA;
                        end
                    end
                    EXECUTA: begin
                        // Confirm presses are ignored while the ALU settles.
                        contador <= contador + 4'd1;
                        if (contador == ULTIMO) begin
                            res_reg   <= bus.Resultado_in;
                            flags_reg <= bus.Flags_in;
                            estado    <= EXIBE;
                        end
                    end
                    EXIBE: begin
                        if (pulso) begin
                            if (bus.Acumula_in) begin
                                a_reg  <= res_reg;
                                estado <= CARREGA_B;
                            end else begin
                                estado <= CARREGA_A;
                            end
                        end
                    end
                    default: estado <= CARREGA_A;
                endcase
            end
        end
    end

    assign bus.A_out         = a_reg;
    assign bus.B_out         = b_reg;
    assign bus.C_out         = c_reg;
    assign bus.Operacao_out  = op_reg;
    assign bus.Resultado_out = res_reg;
    assign bus.Flags_out     = flags_reg;
    assign bus.Estado_out    = estado;
    assign bus.Valido_out    = (estado == EXIBE);

endmodule

// File: tb/tb_ula_sequenciador.sv
module tb_ula_sequenciador;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Driver variables, index 0 -> ESPERA=2, 1 -> ESPERA=1, 2 -> ESPERA=4
    logic [7:0] dado [3];
    logic       conf [3];
    logic       canc [3];
    logic       acum [3];

    ula_seq_if #(.LARGURA(8)) bus2 ();
    ula_seq_if #(.LARGURA(8)) bus1 ();
    ula_seq_if #(.LARGURA(8)) bus4 ();

    // ALU stub: A + B + C, flags = {carry, zero, msb}
    function automatic logic [10:0] alu(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + {8'd0, c};
        return {s[8], (s[7:0] == 8'd0), s[7], s[7:0]};
    endfunction

    logic [10:0] alu2, alu1, alu4;
    assign alu2 = alu(bus2.A_out, bus2.B_out, bus2.C_out);
    assign alu1 = alu(bus1.A_out, bus1.B_out, bus1.C_out);
    assign alu4 = alu(bus4.A_out, bus4.B_out, bus4.C_out);

    assign bus2.Dado_in = dado[0]; assign bus2.Confirma_in = conf[0];
    assign bus2.Cancela_in = canc[0]; assign bus2.Acumula_in = acum[0];
    assign bus2.Resultado_in = alu2[7:0]; assign bus2.Flags_in = alu2[10:8];
    assign bus1.Dado_in = dado[1]; assign bus1.Confirma_in = conf[1];
    assign bus1.Cancela_in = canc[1]; assign bus1.Acumula_in = acum[1];
    assign bus1.Resultado_in = alu1[7:0]; assign bus1.Flags_in = alu1[10:8];
    assign bus4.Dado_in = dado[2]; assign bus4.Confirma_in = conf[2];
    assign bus4.Cancela_in = canc[2]; assign bus4.Acumula_in = acum[2];
    assign bus4.Resultado_in = alu4[7:0]; assign bus4.Flags_in = alu4[10:8];

    ula_sequenciador #(.LARGURA(8), .ESPERA_CICLOS(2)) dut2 (.Clock_in(clk), .Reset_in(rst), .bus(bus2));
    ula_sequenciador #(.LARGURA(8), .ESPERA_CICLOS(1)) dut1 (.Clock_in(clk), .Reset_in(rst), .bus(bus1));
    ula_sequenciador #(.LARGURA(8), .ESPERA_CICLOS(4)) dut4 (.Clock_in(clk), .Reset_in(rst), .bus(bus4));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One press: pulse edge, then release edge.
    task automatic press(input int k, input logic [7:0] d);
        dado[k] = d;
        conf[k] = 1'b1;
        step();
        conf[k] = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        conf[0] = 1'b1;
        dado[0] = 8'hAA;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        total++;
        if (bus2.Estado_out !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus2.Estado_out); end
        total++;
        if (bus2.A_out !== 8'h00) begin bad++; $display("FAIL reset_held_a got=%h exp=00", bus2.A_out); end
        total++;
        if ({bus2.B_out, bus2.C_out, bus2.Operacao_out, bus2.Resultado_out, bus2.Flags_out, bus2.Valido_out} !== 24'd0)
        begin bad++; $display("FAIL reset_outputs got nonzero exp=0"); end
        conf[0] = 1'b0;
        step();
        total++;
        if (bus2.Estado_out !== 3'd0) begin bad++; $display("FAIL reset_release_state got=%0d exp=0", bus2.Estado_out); end
    endtask

    task automatic test_load_execute();
        press(0, 8'h3C);
        total++;
        if (bus2.A_out !== 8'h3C || bus2.Estado_out !== 3'd1) begin bad++; $display("FAIL load_a got a=%h st=%0d exp a=3c st=1", bus2.A_out, bus2.Estado_out); end
        press(0, 8'h05);
        total++;
        if (bus2.B_out !== 8'h05 || bus2.Estado_out !== 3'd2) begin bad++; $display("FAIL load_b got b=%h st=%0d exp b=05 st=2", bus2.B_out, bus2.Estado_out); end
        dado[0] = 8'h08;
        conf[0] = 1'b1;
        step();
        conf[0] = 1'b0;
        total++;
        if (bus2.Estado_out !== 3'd3 || bus2.C_out !== 1'b1 || bus2.Operacao_out !== 3'd0)
        begin bad++; $display("FAIL load_op got st=%0d c=%b op=%0d exp st=3 c=1 op=0", bus2.Estado_out, bus2.C_out, bus2.Operacao_out); end
        step();
        total++;
        if (bus2.Estado_out !== 3'd3 || bus2.Valido_out !== 1'b0) begin bad++; $display("FAIL exec_cycle2 got st=%0d v=%b exp st=3 v=0", bus2.Estado_out, bus2.Valido_out); end
        step();
        total++;
        if (bus2.Estado_out !== 3'd4 || bus2.Valido_out !== 1'b1 || bus2.Resultado_out !== 8'h42 || bus2.Flags_out !== 3'b000)
        begin bad++; $display("FAIL capture got st=%0d v=%b r=%h f=%b exp st=4 v=1 r=42 f=000", bus2.Estado_out, bus2.Valido_out, bus2.Resultado_out, bus2.Flags_out); end
    endtask

    task automatic test_accumulate();
        acum[0] = 1'b1;
        press(0, 8'hFF);
        acum[0] = 1'b0;
        total++;
        if (bus2.A_out !== 8'h42 || bus2.Estado_out !== 3'd1) begin bad++; $display("FAIL accum_a got a=%h st=%0d exp a=42 st=1", bus2.A_out, bus2.Estado_out); end
        press(0, 8'h10);
        dado[0] = 8'h00;
        conf[0] = 1'b1;
        step();
        conf[0] = 1'b0;
        step();
        step();
        total++;
        if (bus2.Resultado_out !== 8'h52 || bus2.Estado_out !== 3'd4) begin bad++; $display("FAIL accum_result got r=%h st=%0d exp r=52 st=4", bus2.Resultado_out, bus2.Estado_out); end
        press(0, 8'h00);
        total++;
        if (bus2.Estado_out !== 3'd0 || bus2.A_out !== 8'h42) begin bad++; $display("FAIL exibe_no_accum got st=%0d a=%h exp st=0 a=42", bus2.Estado_out, bus2.A_out); end
    endtask

    task automatic test_cancel();
        int seen_valid;
        press(0, 8'h11);
        dado[0] = 8'h77;
        conf[0] = 1'b1;
        canc[0] = 1'b1;
        step();
        conf[0] = 1'b0;
        canc[0] = 1'b0;
        total++;
        if (bus2.Estado_out !== 3'd0 || bus2.B_out !== 8'h10) begin bad++; $display("FAIL cancel_b got st=%0d b=%h exp st=0 b=10", bus2.Estado_out, bus2.B_out); end
        step();
        press(0, 8'h01);
        press(0, 8'h02);
        dado[0] = 8'h00;
        conf[0] = 1'b1;
        step();
        conf[0] = 1'b0;
        canc[0] = 1'b1;
        step();
        canc[0] = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus2.Valido_out !== 1'b0) seen_valid++;
            step();
        end
        total++;
        if (seen_valid != 0 || bus2.Estado_out !== 3'd0) begin bad++; $display("FAIL cancel_exec_valid got valid_cycles=%0d st=%0d exp 0 st=0", seen_valid, bus2.Estado_out); end
        total++;
        if (bus2.Resultado_out !== 8'h52) begin bad++; $display("FAIL cancel_exec_result got=%h exp=52", bus2.Resultado_out); end
    endtask

    task automatic test_held_confirm();
        dado[0] = 8'h5A;
        conf[0] = 1'b1;
        step();
        dado[0] = 8'hA5;
        for (int i = 0; i < 19; i++) step();
        total++;
        if (bus2.Estado_out !== 3'd1 || bus2.A_out !== 8'h5A || bus2.B_out !== 8'h02)
        begin bad++; $display("FAIL held_confirm got st=%0d a=%h b=%h exp st=1 a=5a b=02", bus2.Estado_out, bus2.A_out, bus2.B_out); end
        conf[0] = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_execute();
        press(0, 8'h03);
        dado[0] = 8'h01;
        conf[0] = 1'b1;
        step();
        conf[0] = 1'b0;
        total++;
        if (bus2.Estado_out !== 3'd3) begin bad++; $display("FAIL pre_reset_exec got st=%0d exp=3", bus2.Estado_out); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({bus2.A_out, bus2.B_out, bus2.C_out, bus2.Operacao_out, bus2.Resultado_out, bus2.Flags_out, bus2.Estado_out, bus2.Valido_out} !== 36'd0)
        begin bad++; $display("FAIL reset_mid_exec got a=%h b=%h r=%h st=%0d exp all 0", bus2.A_out, bus2.B_out, bus2.Resultado_out, bus2.Estado_out); end
        step();
    endtask

    task automatic test_wait_cycles();
        int n;
        // ESPERA_CICLOS = 1: 0x80 + 0x80 + 1 = 0x101
        press(1, 8'h80);
        press(1, 8'h80);
        dado[1] = 8'h08;
        conf[1] = 1'b1;
        step();
        conf[1] = 1'b0;
        n = 0;
        while (bus1.Valido_out !== 1'b1 && n < 20) begin step(); n++; end
        total++;
        if (n != 1) begin bad++; $display("FAIL wait1_cycles got=%0d exp=1", n); end
        total++;
        if (bus1.Resultado_out !== 8'h01 || bus1.Flags_out !== 3'b100) begin bad++; $display("FAIL wait1_result got r=%h f=%b exp r=01 f=100", bus1.Resultado_out, bus1.Flags_out); end
        // ESPERA_CICLOS = 4: 0xFF + 0x01 + 0 = 0x100
        press(2, 8'hFF);
        press(2, 8'h01);
        dado[2] = 8'hF0;
        conf[2] = 1'b1;
        step();
        conf[2] = 1'b0;
        n = 0;
        while (bus4.Valido_out !== 1'b1 && n < 20) begin step(); n++; end
        total++;
        if (n != 4) begin bad++; $display("FAIL wait4_cycles got=%0d exp=4", n); end
        total++;
        if (bus4.Resultado_out !== 8'h00 || bus4.Flags_out !== 3'b110) begin bad++; $display("FAIL wait4_result got r=%h f=%b exp r=00 f=110", bus4.Resultado_out, bus4.Flags_out); end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            dado[k] = 8'h00;
            conf[k] = 1'b0;
            canc[k] = 1'b0;
            acum[k] = 1'b0;
        end
        test_reset();
        test_load_execute();
        test_accumulate();
        test_cancel();
        test_held_confirm();
        test_reset_mid_execute();
        test_wait_cycles();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
